// File: rtl/codec_i2s_port.sv
// I2S front end for the WM8731 codec. The codec masters bclk and both lrcks.
// Record path: the left ADC slot is deserialised into one mono sample per frame and
// handed downstream with valid/ready.
// Playback path: one sample per frame is requested upstream and serialised into both
// DAC slots.
module codec_i2s_port #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             aud_bclk,
  input  logic             aud_adclrck,
  input  logic             aud_daclrck,
  input  logic             aud_adcdat,
  output logic             aud_dacdat,
  input  logic             rec_en,
  input  logic             play_en,
  output logic [WIDTH-1:0] rec_data,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             play_req,
  input  logic [WIDTH-1:0] play_data,
  input  logic             play_valid,
  output logic             overrun,
  output logic             underrun,
  input  logic             clr_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge strobes
  // ---------------------------------------------------------------------------
  // [0] first flop, [1] synchronised level, [2] previous level for edge detection
  logic [2:0] bclk_sync_q;
  logic [2:0] adclr_sync_q;
  logic [2:0] daclr_sync_q;
  logic [1:0] adcdat_sync_q;

  logic bclk_rise_q;
  logic bclk_fall_q;
  logic adc_lr_fall_q;
  logic dac_lr_fall_q;
  logic dac_lr_edge_q;

  // Two-flop synchronisers plus one history flop per clock-like input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q   <= '0;
      adclr_sync_q  <= '0;
      daclr_sync_q  <= '0;
      adcdat_sync_q <= '0;
    end else begin
      bclk_sync_q   <= {bclk_sync_q[1:0], aud_bclk};
      adclr_sync_q  <= {adclr_sync_q[1:0], aud_adclrck};
      daclr_sync_q  <= {daclr_sync_q[1:0], aud_daclrck};
      adcdat_sync_q <= {adcdat_sync_q[0], aud_adcdat};
    end
  end

  // Registered one-cycle edge strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_rise_q   <= 1'b0;
      bclk_fall_q   <= 1'b0;
      adc_lr_fall_q <= 1'b0;
      dac_lr_fall_q <= 1'b0;
      dac_lr_edge_q <= 1'b0;
    end else begin
      bclk_rise_q   <= bclk_sync_q[1] & ~bclk_sync_q[2];
      bclk_fall_q   <= ~bclk_sync_q[1] & bclk_sync_q[2];
      adc_lr_fall_q <= ~adclr_sync_q[1] & adclr_sync_q[2];
      dac_lr_fall_q <= ~daclr_sync_q[1] & daclr_sync_q[2];
      dac_lr_edge_q <= daclr_sync_q[1] ^ daclr_sync_q[2];
    end
  end

  // ---------------------------------------------------------------------------
  // ADC capture FSM (left slot only)
  // ---------------------------------------------------------------------------
  // The completion step is folded into the last shift so that rec_valid rises one clk
  // after the strobe of the final bit; the FSM then returns straight to StWaitFrame.
  typedef enum logic [1:0] {StWaitFrame, StSkip, StShift} adc_state_e;

  adc_state_e       adc_state_q, adc_state_d;
  logic [CntW-1:0]  adc_cnt_q, adc_cnt_d;
  logic [WIDTH-1:0] adc_sr_q, adc_sr_d;
  logic             adc_done;

  // ADC state, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_state_q <= StWaitFrame;
      adc_cnt_q   <= '0;
      adc_sr_q    <= '0;
    end else begin
      adc_state_q <= adc_state_d;
      adc_cnt_q   <= adc_cnt_d;
      adc_sr_q    <= adc_sr_d;
    end
  end

  // ADC next state; a left-slot start restarts capture from any state
  always_comb begin
    adc_state_d = adc_state_q;
    adc_cnt_d   = adc_cnt_q;
    adc_sr_d    = adc_sr_q;
    adc_done    = 1'b0;
    if (adc_lr_fall_q) begin
      adc_state_d = StSkip;
      adc_cnt_d   = '0;
      adc_sr_d    = '0;
    end else begin
      unique case (adc_state_q)
        StWaitFrame: ;
        StSkip: begin
          // First rising bclk of the slot is the one-bit I2S delay
          if (bclk_rise_q) begin
            adc_state_d = StShift;
            adc_cnt_d   = '0;
          end
        end
        StShift: begin
          if (bclk_rise_q) begin
            adc_sr_d = {adc_sr_q[WIDTH-2:0], adcdat_sync_q[1]};
            if (adc_cnt_q == CntW'(WIDTH - 1)) begin
              adc_done    = 1'b1;
              adc_state_d = StWaitFrame;
              adc_cnt_d   = '0;
            end else begin
              adc_cnt_d = adc_cnt_q + CntW'(1);
            end
          end
        end
        default: adc_state_d = StWaitFrame;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Record handshake and overrun flag
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rec_data_q, rec_data_d;
  logic             rec_valid_q, rec_valid_d;
  logic             overrun_q, overrun_d;

  // Record output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rec_data_q  <= rec_data_d;
      rec_valid_q <= rec_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // A new sample replaces an unaccepted one; setting overrun beats clr_err
  always_comb begin
    rec_data_d  = rec_data_q;
    rec_valid_d = rec_valid_q;
    overrun_d   = overrun_q;
    if (rec_valid_q && rec_ready) begin
      rec_valid_d = 1'b0;
    end
    if (clr_err) begin
      overrun_d = 1'b0;
    end
    if (adc_done && rec_en) begin
      if (rec_valid_q && !rec_ready) begin
        overrun_d = 1'b1;
      end
      rec_data_d  = adc_sr_d;
      rec_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Playback request, buffering and underrun flag
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] play_buf_q, play_buf_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             pending_q, pending_d;
  logic             play_req_q, play_req_d;
  logic             underrun_q, underrun_d;

  // Playback buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_buf_q <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      play_req_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      play_buf_q <= play_buf_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      play_req_q <= play_req_d;
      underrun_q <= underrun_d;
    end
  end

  // Each left-slot start latches the buffered sample and asks upstream for the next one.
  // An unanswered request leaves play_buf alone so the last sample repeats.
  always_comb begin
    play_buf_d = play_buf_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    play_req_d = 1'b0;
    underrun_d = underrun_q;
    if (clr_err) begin
      underrun_d = 1'b0;
    end
    if (!play_en) begin
      pending_d = 1'b0;
    end else if (dac_lr_fall_q) begin
      hold_d     = play_buf_q;
      play_req_d = 1'b1;
      pending_d  = 1'b1;
      if (pending_q) begin
        underrun_d = 1'b1;
      end
    end else if (pending_q && play_valid) begin
      play_buf_d = play_data;
      pending_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // DAC serialiser
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] dac_sr_q, dac_sr_d;
  logic [CntW-1:0]  dac_cnt_q, dac_cnt_d;
  logic             dac_skip_q, dac_skip_d;
  logic             dacdat_q, dacdat_d;

  // DAC shift register, bit counter and output bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_sr_q   <= '0;
      dac_cnt_q  <= '0;
      dac_skip_q <= 1'b0;
      dacdat_q   <= 1'b0;
    end else begin
      dac_sr_q   <= dac_sr_d;
      dac_cnt_q  <= dac_cnt_d;
      dac_skip_q <= dac_skip_d;
      dacdat_q   <= dacdat_d;
    end
  end

  // Load on every lrck edge, skip one falling bclk, then shift MSB first
  always_comb begin
    dac_sr_d   = dac_sr_q;
    dac_cnt_d  = dac_cnt_q;
    dac_skip_d = dac_skip_q;
    dacdat_d   = dacdat_q;
    if (dac_lr_edge_q) begin
      // hold_d so the left slot sees the sample latched on this very edge
      dac_sr_d  = play_en ? hold_d : '0;
      dac_cnt_d = '0;
      // lrck toggles on a falling bclk; when both strobes coincide that fall is the skip
      dac_skip_d = ~bclk_fall_q;
    end else if (bclk_fall_q) begin
      if (dac_skip_q) begin
        dac_skip_d = 1'b0;
      end else if (dac_cnt_q < CntW'(WIDTH)) begin
        dacdat_d  = dac_sr_q[WIDTH-1];
        dac_sr_d  = {dac_sr_q[WIDTH-2:0], 1'b0};
        dac_cnt_d = dac_cnt_q + CntW'(1);
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  assign aud_dacdat = dacdat_q;
  assign rec_data   = rec_data_q;
  assign rec_valid  = rec_valid_q;
  assign overrun    = overrun_q;
  assign play_req   = play_req_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_codec_i2s_port.sv
// Bench for codec_i2s_port: a codec model drives I2S frames, a record monitor and a
// playback responder run alongside, and each test compares scoreboard queues.
`timescale 1ns/1ps
module tb_codec_i2s_port;

  localparam int HalfClk = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aud_bclk, aud_adclrck, aud_daclrck, aud_adcdat, aud_dacdat;
  logic        rec_en, play_en, rec_valid, rec_ready, play_req, play_valid;
  logic        overrun, underrun, clr_err;
  logic [15:0] rec_data, play_data;

  int          n_run, n_fail, req_cnt;
  logic        resp_en;
  logic [15:0] resp_word;
  logic [15:0] rec_exp_q[$], rec_got_q[$], dac_exp_q[$], dac_got_q[$];

  always #5 clk = ~clk;

  codec_i2s_port #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .aud_bclk   (aud_bclk),
    .aud_adclrck(aud_adclrck),
    .aud_daclrck(aud_daclrck),
    .aud_adcdat (aud_adcdat),
    .aud_dacdat (aud_dacdat),
    .rec_en     (rec_en),
    .play_en    (play_en),
    .rec_data   (rec_data),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .play_req   (play_req),
    .play_data  (play_data),
    .play_valid (play_valid),
    .overrun    (overrun),
    .underrun   (underrun),
    .clr_err    (clr_err)
  );

  // Record monitor: every accepted sample goes to the got queue
  initial begin
    forever begin
      @(negedge clk);
      if (rec_valid === 1'b1 && rec_ready === 1'b1) rec_got_q.push_back(rec_data);
    end
  end

  // Upstream playback stage: answers each request with resp_word when enabled
  initial begin
    play_valid = 1'b0;
    play_data  = 16'h0;
    forever begin
      @(negedge clk);
      if (play_req === 1'b1) begin
        req_cnt++;
        if (resp_en) begin
          play_valid = 1'b1;
          play_data  = resp_word;
          @(negedge clk);
          play_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  task automatic half_bclk();
    repeat (HalfClk) @(posedge clk);
    #2;
  endtask

  task automatic idle_bclk(input logic adc_lr, input logic dac_lr);
    aud_bclk    = 1'b0;
    aud_adclrck = adc_lr;
    aud_daclrck = dac_lr;
    aud_adcdat  = 1'b0;
    half_bclk();
    aud_bclk = 1'b1;
    half_bclk();
  endtask

  // One 64-bclk I2S frame; captures the DAC slots at rising bclk. stop_at > 0 returns
  // after that many left-slot bits (bclk high, lrck low) without logging DAC words.
  task automatic send_frame(input logic [15:0] left, input logic [15:0] right,
                            input int stop_at);
    logic [15:0] dl, dr;
    dl = 16'h0;
    dr = 16'h0;
    for (int i = 0; i < 64; i++) begin
      int          j;
      logic [15:0] w;
      j = i % 32;
      w = (i < 32) ? left : right;
      aud_bclk = 1'b0;
      if (i == 0) begin
        aud_adclrck = 1'b0;
        aud_daclrck = 1'b0;
      end
      if (i == 32) begin
        aud_adclrck = 1'b1;
        aud_daclrck = 1'b1;
      end
      aud_adcdat = (j >= 1 && j <= 16) ? w[16-j] : 1'b0;
      half_bclk();
      aud_bclk = 1'b1;
      if (j >= 1 && j <= 16) begin
        if (i < 32) dl[16-j] = aud_dacdat;
        else        dr[16-j] = aud_dacdat;
      end
      half_bclk();
      if (stop_at > 0 && i == stop_at) return;
    end
    dac_got_q.push_back(dl);
    dac_got_q.push_back(dr);
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    flags = {aud_dacdat, rec_valid, play_req, overrun, underrun};
    n_run++;
    if (rec_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rec_data: got %h want %h", rec_data, 16'h0);
    end
    n_run++;
    if (flags !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want %b", flags, 5'b0);
    end
  endtask

  task automatic test_record();
    logic [15:0] e, g;
    rec_en = 1'b1;
    rec_ready = 1'b1;
    rec_got_q.delete();
    dac_got_q.delete();
    req_cnt = 0;
    rec_exp_q.push_back(16'hA5C3);
    dac_exp_q.push_back(16'h0);
    dac_exp_q.push_back(16'h0);
    send_frame(16'hA5C3, 16'hFFFF, 0);
    repeat (4) @(posedge clk);
    #2;
    n_run++;
    if (rec_got_q.size() != rec_exp_q.size()) begin
      n_fail++;
      $display("FAIL record_count: got %0d want %0d", rec_got_q.size(), rec_exp_q.size());
    end
    while (rec_exp_q.size() > 0) begin
      e = rec_exp_q.pop_front();
      g = (rec_got_q.size() > 0) ? rec_got_q.pop_front() : 16'hxxxx;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL record_data: got %h want %h", g, e);
      end
    end
    n_run++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL record_overrun: got %b want 0", overrun);
    end
    while (dac_exp_q.size() > 0) begin
      e = dac_exp_q.pop_front();
      g = (dac_got_q.size() > 0) ? dac_got_q.pop_front() : 16'hxxxx;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL record_dac_idle: got %h want %h", g, e);
      end
    end
    n_run++;
    if (req_cnt != 0) begin
      n_fail++;
      $display("FAIL record_no_req: got %0d want 0", req_cnt);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] e, g;
    rec_ready = 1'b0;
    rec_got_q.delete();
    send_frame(16'h1111, 16'hFFFF, 0);
    send_frame(16'h2222, 16'hFFFF, 0);
    n_run++;
    if (rec_valid !== 1'b1 || rec_data !== 16'h2222) begin
      n_fail++;
      $display("FAIL overrun_hold: got valid=%b data=%h want valid=1 data=2222",
               rec_valid, rec_data);
    end
    n_run++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    clr_err = 1'b1;
    @(posedge clk);
    #2;
    clr_err = 1'b0;
    n_run++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
    rec_exp_q.push_back(16'h2222);
    rec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_run++;
    if (rec_got_q.size() != rec_exp_q.size() || rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_drain: got count=%0d valid=%b want count=%0d valid=0",
               rec_got_q.size(), rec_valid, rec_exp_q.size());
    end
    while (rec_exp_q.size() > 0) begin
      e = rec_exp_q.pop_front();
      g = (rec_got_q.size() > 0) ? rec_got_q.pop_front() : 16'hxxxx;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL overrun_drain_data: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_playback();
    logic [15:0] e, g;
    rec_en = 1'b0;
    play_en = 1'b1;
    resp_en = 1'b1;
    resp_word = 16'h8001;
    req_cnt = 0;
    dac_got_q.delete();
    // First frame still plays the empty buffer; the answer appears one frame later
    dac_exp_q.push_back(16'h0);
    dac_exp_q.push_back(16'h0);
    for (int k = 0; k < 4; k++) dac_exp_q.push_back(16'h8001);
    for (int k = 0; k < 3; k++) send_frame(16'h0, 16'h0, 0);
    while (dac_exp_q.size() > 0) begin
      e = dac_exp_q.pop_front();
      g = (dac_got_q.size() > 0) ? dac_got_q.pop_front() : 16'hxxxx;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL playback_dac: got %h want %h", g, e);
      end
    end
    n_run++;
    if (req_cnt != 3 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL playback_req: got reqs=%0d underrun=%b want reqs=3 underrun=0",
               req_cnt, underrun);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] e, g;
    dac_got_q.delete();
    resp_word = 16'h4321;
    dac_exp_q.push_back(16'h8001);
    dac_exp_q.push_back(16'h8001);
    send_frame(16'h0, 16'h0, 0);
    resp_en = 1'b0;
    dac_exp_q.push_back(16'h4321);
    dac_exp_q.push_back(16'h4321);
    send_frame(16'h0, 16'h0, 0);
    n_run++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_early: got %b want 0", underrun);
    end
    resp_en = 1'b1;
    resp_word = 16'h5555;
    dac_exp_q.push_back(16'h4321);
    dac_exp_q.push_back(16'h4321);
    send_frame(16'h0, 16'h0, 0);
    n_run++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_set: got %b want 1", underrun);
    end
    dac_exp_q.push_back(16'h5555);
    dac_exp_q.push_back(16'h5555);
    send_frame(16'h0, 16'h0, 0);
    while (dac_exp_q.size() > 0) begin
      e = dac_exp_q.pop_front();
      g = (dac_got_q.size() > 0) ? dac_got_q.pop_front() : 16'hxxxx;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL underrun_dac: got %h want %h", g, e);
      end
    end
    clr_err = 1'b1;
    @(posedge clk);
    #2;
    clr_err = 1'b0;
    n_run++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e, g;
    logic [4:0]  flags;
    rec_en = 1'b1;
    rec_ready = 1'b1;
    rec_got_q.delete();
    send_frame(16'hFFFF, 16'h0, 8);
    rst_n = 1'b0;
    #1;
    flags = {aud_dacdat, rec_valid, play_req, overrun, underrun};
    n_run++;
    if (rec_data !== 16'h0 || flags !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got data=%h flags=%b want data=0000 flags=00000",
               rec_data, flags);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    play_en = 1'b0;
    idle_bclk(1'b1, 1'b1);
    rec_exp_q.push_back(16'h3C5A);
    send_frame(16'h3C5A, 16'hFFFF, 0);
    repeat (4) @(posedge clk);
    #2;
    n_run++;
    if (rec_got_q.size() != rec_exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %0d want %0d", rec_got_q.size(), rec_exp_q.size());
    end
    while (rec_exp_q.size() > 0) begin
      e = rec_exp_q.pop_front();
      g = (rec_got_q.size() > 0) ? rec_got_q.pop_front() : 16'hxxxx;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_mid_data: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_lr_glitch();
    logic [15:0] e, g;
    rec_got_q.delete();
    send_frame(16'hF0F0, 16'hFFFF, 7);
    // Early left-slot restart: ADC lrck high for one bclk, then a fresh frame
    idle_bclk(1'b1, 1'b0);
    rec_exp_q.push_back(16'h6B9D);
    send_frame(16'h6B9D, 16'hFFFF, 0);
    repeat (4) @(posedge clk);
    #2;
    n_run++;
    if (rec_got_q.size() != rec_exp_q.size()) begin
      n_fail++;
      $display("FAIL glitch_count: got %0d want %0d", rec_got_q.size(), rec_exp_q.size());
    end
    while (rec_exp_q.size() > 0) begin
      e = rec_exp_q.pop_front();
      g = (rec_got_q.size() > 0) ? rec_got_q.pop_front() : 16'hxxxx;
      n_run++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL glitch_data: got %h want %h", g, e);
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    req_cnt = 0;
    rst_n = 1'b0;
    aud_bclk = 1'b1;
    aud_adclrck = 1'b1;
    aud_daclrck = 1'b1;
    aud_adcdat = 1'b0;
    rec_en = 1'b0;
    play_en = 1'b0;
    rec_ready = 1'b0;
    clr_err = 1'b0;
    resp_en = 1'b0;
    resp_word = 16'h0;
    repeat (5) @(posedge clk);
    #2;
    test_reset();
    rst_n = 1'b1;
    idle_bclk(1'b1, 1'b1);
    idle_bclk(1'b1, 1'b1);
    test_record();
    test_overrun();
    test_playback();
    test_underrun();
    test_reset_mid();
    test_lr_glitch();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
